// File: rtl/gray_pkg.sv
// Shared constants, operation encoding and Gray-code helpers for the
// gray_code_counter slice and its consumers.
package gray_pkg;

  localparam int unsigned GRAY_WIDTH_DEFAULT = 4;
  localparam int unsigned GRAY_WIDTH_MAX     = 16;

  typedef enum logic [2:0] {
    OP_HOLD,
    OP_CLEAR,
    OP_LOAD,
    OP_UP,
    OP_DOWN
  } op_e;

  function automatic logic [GRAY_WIDTH_MAX-1:0] bin2gray(
    input logic [GRAY_WIDTH_MAX-1:0] b
  );
    return b ^ (b >> 1);
  endfunction

  // True when the two codes differ in exactly one bit position.
  function automatic logic gray_onehot_diff(
    input logic [GRAY_WIDTH_MAX-1:0] a,
    input logic [GRAY_WIDTH_MAX-1:0] b
  );
    logic [GRAY_WIDTH_MAX-1:0] x;
    x = a ^ b;
    return (x != '0) && ((x & (x - 1'b1)) == '0);
  endfunction

endpackage

// File: rtl/gray_code_counter_if.sv
// Control and result bundle of the Gray-code counter.
interface gray_code_counter_if
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
);

  logic             en;
  logic             up_dn;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] gray_out;
  logic             wrap;
  logic             step;

  modport master (
    output en, up_dn, clear, load, load_val,
    input  gray_out, wrap, step
  );

  modport slave (
    input  en, up_dn, clear, load, load_val,
    output gray_out, wrap, step
  );

endinterface

// File: rtl/gray_code_counter_bin_to_gray.sv
// Combinational binary to reflected-binary Gray encoder.
module bin_to_gray #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_code_counter.sv
// Registered up/down binary counter whose output register holds the Gray
// encoding of the next count, so gray_out tracks the count with no lag.
module gray_code_counter
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = GRAY_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  gray_code_counter_if.slave  bus
);

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] next_cnt;
  logic [WIDTH-1:0] next_gray;
  logic             next_wrap;
  logic             next_step;
  op_e              op;

  // Priority: clear, then load, then an enabled count step.
  always_comb begin
    op = OP_HOLD;
    if (bus.clear)     op = OP_CLEAR;
    else if (bus.load) op = OP_LOAD;
    else if (bus.en)   op = bus.up_dn ? OP_UP : OP_DOWN;
  end

  always_comb begin
    next_cnt  = cnt;
    next_wrap = 1'b0;
    next_step = 1'b0;
    unique case (op)
      OP_CLEAR: next_cnt = '0;
      OP_LOAD:  next_cnt = bus.load_val;
      OP_UP: begin
        next_cnt  = cnt + WIDTH'(1);
        next_wrap = &cnt;
        next_step = 1'b1;
      end
      OP_DOWN: begin
        next_cnt  = cnt - WIDTH'(1);
        next_wrap = ~|cnt;
        next_step = 1'b1;
      end
      default: next_cnt = cnt;
    endcase
  end

  bin_to_gray #(
    .WIDTH (WIDTH)
  ) u_bin_to_gray (
    .bin  (next_cnt),
    .gray (next_gray)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      bus.gray_out <= '0;
      bus.wrap     <= 1'b0;
      bus.step     <= 1'b0;
    end else begin
      cnt          <= next_cnt;
      bus.gray_out <= next_gray;
      bus.wrap     <= next_wrap;
      bus.step     <= next_step;
    end
  end

endmodule

// File: tb/tb_gray_code_counter.sv
// Self-checking bench for gray_code_counter: directed literal sequences plus
// randomized traffic against an integer reference count and a Gray decoder.
module tb_gray_code_counter;
  import gray_pkg::*;

  localparam int unsigned W   = 4;
  localparam int          MOD = 1 << W;

  logic clk;
  logic rst_n;

  gray_code_counter_if #(.WIDTH(W)) bif ();

  gray_code_counter #(
    .WIDTH (W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference: plain integer count modulo 2^W.
  int m_cnt  = 0;
  bit m_wrap = 0;
  bit m_step = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt  <= 0;
      m_wrap <= 0;
      m_step <= 0;
    end else if (bif.clear) begin
      m_cnt  <= 0;
      m_wrap <= 0;
      m_step <= 0;
    end else if (bif.load) begin
      m_cnt  <= int'(bif.load_val);
      m_wrap <= 0;
      m_step <= 0;
    end else if (bif.en && bif.up_dn) begin
      m_cnt  <= (m_cnt + 1) % MOD;
      m_wrap <= (m_cnt == MOD - 1);
      m_step <= 1;
    end else if (bif.en) begin
      m_cnt  <= (m_cnt + MOD - 1) % MOD;
      m_wrap <= (m_cnt == 0);
      m_step <= 1;
    end else begin
      m_wrap <= 0;
      m_step <= 0;
    end
  end

  // Downstream Gray-to-binary converter model.
  function automatic int g2b(input logic [W-1:0] g);
    int b;
    int acc;
    b   = 0;
    acc = 0;
    for (int i = W - 1; i >= 0; i--) begin
      acc = acc ^ int'(g[i]);
      b   = b | (acc << i);
    end
    return b;
  endfunction

  bit         run_chk = 0;
  logic [W-1:0] prev_gray = '0;

  always @(negedge clk) begin
    if (run_chk) begin
      chk("decoded_count", g2b(bif.gray_out), m_cnt);
      chk("gray_code", int'(bif.gray_out), m_cnt ^ (m_cnt >> 1));
      chk("wrap", int'(bif.wrap), int'(m_wrap));
      chk("step", int'(bif.step), int'(m_step));
      if (bif.step)
        chk("onehot_diff",
            int'(gray_onehot_diff(16'(prev_gray), 16'(bif.gray_out))), 1);
    end
    prev_gray = bif.gray_out;
  end

  // Caller sits at negedge+1; drive, let one rising edge pass, return at negedge+1.
  task automatic tick(input bit c, input bit l, input int lv, input bit e, input bit u);
    bif.clear    = c;
    bif.load     = l;
    bif.load_val = W'(lv);
    bif.en       = e;
    bif.up_dn    = u;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  int up_seq[16] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101,
                     4'b0100, 4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010,
                     4'b1011, 4'b1001, 4'b1000, 4'b0000};

  initial begin
    rst_n        = 1'b0;
    bif.en       = 1'b0;
    bif.up_dn    = 1'b0;
    bif.clear    = 1'b0;
    bif.load     = 1'b0;
    bif.load_val = '0;
    #12;
    chk("reset_gray", int'(bif.gray_out), 0);
    chk("reset_wrap", int'(bif.wrap), 0);
    chk("reset_step", int'(bif.step), 0);
    @(negedge clk);
    #1;
    rst_n   = 1'b1;
    run_chk = 1'b1;

    for (int i = 0; i < 16; i++) begin
      tick(0, 0, 0, 1, 1);
      chk("up_seq_gray", int'(bif.gray_out), up_seq[i]);
      chk("up_seq_wrap", int'(bif.wrap), (i == 15) ? 1 : 0);
      chk("up_seq_step", int'(bif.step), 1);
    end

    tick(0, 0, 0, 1, 0);
    chk("down_wrap_gray", int'(bif.gray_out), 4'b1000);
    chk("down_wrap_wrap", int'(bif.wrap), 1);
    tick(0, 0, 0, 1, 0);
    chk("down2_gray", int'(bif.gray_out), 4'b1001);
    chk("down2_wrap", int'(bif.wrap), 0);

    tick(0, 1, 5, 0, 0);
    chk("load5_gray", int'(bif.gray_out), 4'b0111);
    chk("load5_step", int'(bif.step), 0);
    tick(0, 1, 10, 1, 1);
    chk("load10_gray", int'(bif.gray_out), 4'b1111);
    chk("load10_step", int'(bif.step), 0);

    tick(1, 1, 9, 1, 1);
    chk("clear_wins_gray", int'(bif.gray_out), 0);
    chk("clear_wins_wrap", int'(bif.wrap), 0);
    chk("clear_wins_step", int'(bif.step), 0);
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0, 0, i[0]);
      chk("hold_gray", int'(bif.gray_out), 0);
      chk("hold_step", int'(bif.step), 0);
    end

    for (int i = 0; i < 4; i++) tick(0, 0, 0, 1, 1);
    chk("pre_reset_gray", int'(bif.gray_out), 4'b0110);
    bif.en = 1'b0;
    rst_n  = 1'b0;
    #1;
    chk("async_reset_gray", int'(bif.gray_out), 0);
    #1;
    rst_n = 1'b1;
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 0, 1, 1);
    chk("post_reset_gray", int'(bif.gray_out), 4'b0001);

    for (int i = 0; i < 10000; i++) begin
      tick(($urandom_range(99) < 3), ($urandom_range(99) < 6),
           int'($urandom_range(MOD - 1)), ($urandom_range(99) < 75),
           $urandom_range(1) == 1);
    end

    run_chk = 1'b0;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
